// File: rtl/d2d_pkg.sv
// Shared definitions for the multi-channel die-to-die adapter.
//  - clog2        : constant function used to derive the channel-ID width
//  - d2d_word_t   : {data,addr} word at default widths (the top re-declares
//                   the same layout at its own parameter widths)
//  - parity       : even-parity bit over a zero-extended vector; zero
//                   padding does not change the XOR so one function covers
//                   every word width up to PAR_MAX_W
package d2d_pkg;

  localparam int PAR_MAX_W  = 256;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 16;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] addr;
  } d2d_word_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/d2d_chan_fifo.sv
// Per-channel FIFO. Wrap-around pointers carry one extra MSB so full and
// empty are distinguished without a counter. Read data is the head entry
// (show-ahead), so a pop consumes the word already visible on rdata_o.
// Ports:
//  clk_i, rst_i      clock, synchronous active-high reset (empties FIFO)
//  push_i, wdata_i   write request/data (ignored when full)
//  pop_i             consume head entry (ignored when empty)
//  rdata_o           head entry
//  full_o, empty_o   status
module d2d_chan_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 48
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/d2d_multichannel_adapter.sv
// Multi-channel die-to-die adapter. NUM_CH valid/ready source channels each
// feed a FIFO; a round-robin arbiter drains the FIFOs into one registered
// valid/ready link tagged with channel ID and even parity.
// Ports:
//  clock, reset          clock, synchronous active-high reset
//  srcValid/srcReady     per-channel handshake; srcReady depends only on
//                        FIFO fullness and reset (never on dstReady)
//  srcData/srcAddr       channel i at [i*W +: W]
//  chanEnable            per-channel arbitration eligibility
//  dstValid/dstReady     output handshake
//  dstData/dstAddr       output payload
//  dstChan/dstParity     source channel and ^{data,addr}
module d2d_multichannel_adapter
  import d2d_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 16,
  parameter  int FIFO_DEPTH = 4,
  localparam int CHID_W     = clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        srcValid,
  output logic [NUM_CH-1:0]        srcReady,
  input  logic [NUM_CH*DATA_W-1:0] srcData,
  input  logic [NUM_CH*ADDR_W-1:0] srcAddr,
  input  logic [NUM_CH-1:0]        chanEnable,
  output logic                     dstValid,
  input  logic                     dstReady,
  output logic [DATA_W-1:0]        dstData,
  output logic [ADDR_W-1:0]        dstAddr,
  output logic [CHID_W-1:0]        dstChan,
  output logic                     dstParity
);

  localparam int WORD_W = DATA_W + ADDR_W;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } word_t;

  logic  [NUM_CH-1:0] push, pop, full, empty, req;
  word_t [NUM_CH-1:0] rd_word;

  logic              gnt_vld, load;
  logic [CHID_W-1:0] gnt_id;
  logic [CHID_W-1:0] ptr_q, ptr_d;
  logic              vld_q, vld_d;
  word_t             word_q, word_d;
  logic [CHID_W-1:0] chan_q, chan_d;
  logic              par_q, par_d;

  assign srcReady = ~full & {NUM_CH{~reset}};
  assign push     = srcValid & srcReady;
  assign req      = ~empty & chanEnable;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    d2d_chan_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (WORD_W)
    ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .push_i  (push[i]),
      .wdata_i ({srcData[i*DATA_W +: DATA_W], srcAddr[i*ADDR_W +: ADDR_W]}),
      .pop_i   (pop[i]),
      .rdata_o (rd_word[i]),
      .full_o  (full[i]),
      .empty_o (empty[i])
    );
  end

  // Rotate-priority search starting at ptr_q. Iterating from the farthest
  // offset down lets the nearest requester overwrite, so no early exit.
  always_comb begin
    logic [CHID_W-1:0] idx;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = ptr_q + CHID_W'(k);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  // A grant only takes effect when the output register can load; a stalled
  // link leaves both the FIFO and the RR pointer untouched.
  assign load = (!vld_q || dstReady) && gnt_vld;
  assign pop  = load ? (NUM_CH'(1) << gnt_id) : '0;

  always_comb begin
    vld_d  = vld_q;
    word_d = word_q;
    chan_d = chan_q;
    par_d  = par_q;
    ptr_d  = ptr_q;
    if (load) begin
      vld_d  = 1'b1;
      word_d = rd_word[gnt_id];
      chan_d = gnt_id;
      par_d  = parity(PAR_MAX_W'(rd_word[gnt_id]));
      ptr_d  = gnt_id + CHID_W'(1);
    end else if (dstReady) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q  <= 1'b0;
      word_q <= '0;
      chan_q <= '0;
      par_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      word_q <= word_d;
      chan_q <= chan_d;
      par_q  <= par_d;
      ptr_q  <= ptr_d;
    end
  end

  assign dstValid  = vld_q;
  assign dstData   = word_q.data;
  assign dstAddr   = word_q.addr;
  assign dstChan   = chan_q;
  assign dstParity = par_q;

endmodule

// File: tb/tb_d2d_multichannel_adapter.sv
// Bench for d2d_multichannel_adapter: a per-cycle vector table covering
// single-word latency, four-channel RR order, parity and output hold, then
// hand-written sequences for backpressure fill, channel masking, fairness
// and mid-transfer reset.
module tb_d2d_multichannel_adapter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int AW  = 16;

  logic              clock = 1'b0;
  logic              reset;
  logic [NCH-1:0]    srcValid, srcReady, chanEnable;
  logic [NCH*DW-1:0] srcData;
  logic [NCH*AW-1:0] srcAddr;
  logic              dstValid, dstReady, dstParity;
  logic [DW-1:0]     dstData;
  logic [AW-1:0]     dstAddr;
  logic [1:0]        dstChan;

  int n_cmp = 0;
  int n_err = 0;

  d2d_multichannel_adapter #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .srcValid(srcValid), .srcReady(srcReady),
    .srcData(srcData), .srcAddr(srcAddr),
    .chanEnable(chanEnable),
    .dstValid(dstValid), .dstReady(dstReady),
    .dstData(dstData), .dstAddr(dstAddr),
    .dstChan(dstChan), .dstParity(dstParity)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] dbase;
    logic [15:0] abase;
    logic        rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [15:0] e_addr;
    logic [1:0]  e_chan;
    logic        e_par;
    logic [3:0]  e_srdy;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_inputs();
    srcValid = '0;
    srcData  = '0;
    srcAddr  = '0;
    dstReady = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_inputs();
    chanEnable = 4'hF;
    tick();
    reset = 1'b0;
  endtask

  task automatic set_word(input int ch, input logic [31:0] d, input logic [15:0] a);
    srcData[ch*DW +: DW] = d;
    srcAddr[ch*AW +: AW] = a;
  endtask

  initial begin
    int acc, w, nout, got;
    logic [1:0]  chans [8];
    logic [31:0] datas [8];
    logic [1:0]  exp_rr [6];

    // ---------------- vector table ----------------
    //           rst vld     dbase         abase     rdy  e_vld e_data        e_addr    ch par srdy
    tbl[0]  = '{0, 4'b0001, 32'hA5A5A5A5, 16'h0001, 1,   0, 32'h0,        16'h0,    0, 0, 4'hF};
    tbl[1]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   0, 32'h0,        16'h0,    0, 0, 4'hF};
    tbl[2]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   1, 32'hA5A5A5A5, 16'h0001, 0, 1, 4'hF};
    tbl[3]  = '{1, 4'b0000, 32'h0,        16'h0,    1,   0, 32'h0,        16'h0,    0, 0, 4'h0};
    tbl[4]  = '{0, 4'b1111, 32'h0,        16'h0010, 1,   0, 32'h0,        16'h0,    0, 0, 4'hF};
    tbl[5]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   0, 32'h0,        16'h0,    0, 0, 4'hF};
    tbl[6]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   1, 32'h0,        16'h0010, 0, 1, 4'hF};
    tbl[7]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   1, 32'h1,        16'h0011, 1, 1, 4'hF};
    tbl[8]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   1, 32'h2,        16'h0012, 2, 1, 4'hF};
    tbl[9]  = '{0, 4'b0000, 32'h0,        16'h0,    1,   1, 32'h3,        16'h0013, 3, 1, 4'hF};
    tbl[10] = '{0, 4'b0100, 32'h000000FD, 16'h0001, 1,   0, 32'h0,        16'h0,    0, 0, 4'hF};
    tbl[11] = '{0, 4'b0000, 32'h0,        16'h0,    1,   0, 32'h0,        16'h0,    0, 0, 4'hF};
    tbl[12] = '{0, 4'b0000, 32'h0,        16'h0,    0,   1, 32'h000000FF, 16'h0003, 2, 0, 4'hF};
    tbl[13] = '{0, 4'b0000, 32'h0,        16'h0,    1,   1, 32'h000000FF, 16'h0003, 2, 0, 4'hF};
    tbl[14] = '{0, 4'b0000, 32'h0,        16'h0,    1,   0, 32'h0,        16'h0,    0, 0, 4'hF};

    exp_rr = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2};

    // ---------------- reset state ----------------
    reset = 1'b1;
    clr_inputs();
    chanEnable = 4'hF;
    tick();
    tick();
    chk("rst_dstValid",  64'(dstValid),  64'(0));
    chk("rst_dstData",   64'(dstData),   64'(0));
    chk("rst_dstAddr",   64'(dstAddr),   64'(0));
    chk("rst_dstChan",   64'(dstChan),   64'(0));
    chk("rst_dstParity", 64'(dstParity), 64'(0));
    chk("rst_srcReady",  64'(srcReady),  64'(0));
    reset = 1'b0;

    // ---------------- table ----------------
    for (int i = 0; i < 15; i++) begin
      reset    = tbl[i].rst;
      srcValid = tbl[i].vld;
      dstReady = tbl[i].rdy;
      for (int c = 0; c < NCH; c++)
        set_word(c, 32'(tbl[i].dbase + 32'(c)), 16'(tbl[i].abase + 16'(c)));
      #1;
      chk($sformatf("vec%0d_srcReady", i), 64'(srcReady), 64'(tbl[i].e_srdy));
      chk($sformatf("vec%0d_dstValid", i), 64'(dstValid), 64'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk($sformatf("vec%0d_dstData", i),   64'(dstData),   64'(tbl[i].e_data));
        chk($sformatf("vec%0d_dstAddr", i),   64'(dstAddr),   64'(tbl[i].e_addr));
        chk($sformatf("vec%0d_dstChan", i),   64'(dstChan),   64'(tbl[i].e_chan));
        chk($sformatf("vec%0d_dstParity", i), 64'(dstParity), 64'(tbl[i].e_par));
      end
      tick();
    end
    reset = 1'b0;

    // ---------------- backpressure fill on channel 1 ----------------
    do_reset();
    dstReady = 1'b0;
    w   = 1;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      srcValid = (w <= 8) ? 4'b0010 : 4'b0000;
      set_word(1, 32'(w), 16'h0);
      #1;
      if (srcValid[1] && srcReady[1]) begin
        acc++;
        w++;
      end
      tick();
    end
    chk("bp_accepted",   64'(acc),         64'(5));
    chk("bp_srcReady1",  64'(srcReady[1]), 64'(0));
    chk("bp_hold_valid", 64'(dstValid),    64'(1));
    chk("bp_hold_data",  64'(dstData),     64'(1));
    chk("bp_hold_chan",  64'(dstChan),     64'(1));
    srcValid = '0;
    dstReady = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("bp_drain%0d_valid", k), 64'(dstValid), 64'(1));
      chk($sformatf("bp_drain%0d_data", k),  64'(dstData),  64'(k));
      tick();
    end
    chk("bp_srcReady1_after", 64'(srcReady[1]), 64'(1));
    chk("bp_empty_after",     64'(dstValid),    64'(0));

    // ---------------- channel masking ----------------
    do_reset();
    chanEnable = 4'b1101;
    nout = 0;
    for (int c = 0; c < 10; c++) begin
      srcValid = '0;
      if (c == 0) begin
        srcValid = 4'b0011;
        set_word(0, 32'h50, 16'h0);
        set_word(1, 32'h11, 16'h0);
      end else if (c < 3) begin
        srcValid = 4'b0010;
        set_word(1, 32'(32'h11 + 32'(c)), 16'h0);
      end
      #1;
      if (dstValid && nout < 8) begin
        chans[nout] = dstChan;
        datas[nout] = dstData;
        nout++;
      end
      tick();
    end
    chk("mask_count", 64'(nout), 64'(1));
    if (nout >= 1) begin
      chk("mask_chan0", 64'(chans[0]), 64'(0));
      chk("mask_data0", 64'(datas[0]), 64'(32'h50));
    end
    chanEnable = 4'hF;
    nout = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (dstValid && nout < 8) begin
        chans[nout] = dstChan;
        datas[nout] = dstData;
        nout++;
      end
      tick();
    end
    chk("unmask_count", 64'(nout), 64'(3));
    for (int k = 0; k < 3; k++) begin
      if (k < nout) begin
        chk($sformatf("unmask%0d_chan", k), 64'(chans[k]), 64'(1));
        chk($sformatf("unmask%0d_data", k), 64'(datas[k]), 64'(32'h11 + k));
      end
    end

    // ---------------- fairness between channels 0 and 2 ----------------
    do_reset();
    srcValid = 4'b0101;
    set_word(0, 32'hC0, 16'h0);
    set_word(2, 32'hC2, 16'h0);
    got = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (dstValid && got < 6) begin
        chans[got] = dstChan;
        got++;
      end
      tick();
    end
    chk("rr_count", 64'(got), 64'(6));
    for (int k = 0; k < 6; k++)
      if (k < got) chk($sformatf("rr%0d_chan", k), 64'(chans[k]), 64'(exp_rr[k]));

    // ---------------- reset mid-transfer ----------------
    do_reset();
    dstReady = 1'b0;
    srcValid = 4'hF;
    for (int c = 0; c < NCH; c++) set_word(c, 32'(32'h60 + 32'(c)), 16'h0);
    tick();
    srcValid = '0;
    tick();
    tick();
    chk("mrst_pre_valid", 64'(dstValid), 64'(1));
    reset = 1'b1;
    tick();
    chk("mrst_dstValid", 64'(dstValid), 64'(0));
    chk("mrst_dstData",  64'(dstData),  64'(0));
    chk("mrst_srcReady", 64'(srcReady), 64'(0));
    reset = 1'b0;
    #1;
    chk("mrst_srcReady_rel", 64'(srcReady), 64'(4'hF));
    dstReady = 1'b1;
    nout = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (dstValid) nout++;
    end
    chk("mrst_no_stale", 64'(nout), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
